// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: time-counter command encodings, the
// controller state enumeration and the lap entry width.
package stopwatch_pkg;

    // Command driven to the time counter.
    typedef enum logic [1:0] {
        CNT_CLEAR = 2'b00,
        CNT_RUN   = 2'b01,
        CNT_HOLD  = 2'b10
    } cnt_ctrl_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_RECALL = 2'b11
    } sw_state_e;

    // Six BCD digits per lap entry: {m1, m0, s1, s0, ms1, ms0}.
    localparam int LAP_W = 24;

    // Moore decode of the counter command from the controller state.
    function automatic cnt_ctrl_e state_to_ctrl(input sw_state_e st);
        case (st)
            ST_IDLE:   return CNT_CLEAR;
            ST_RUN:    return CNT_RUN;
            ST_PAUSE:  return CNT_HOLD;
            ST_RECALL: return CNT_HOLD;
            default:   return CNT_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_lap_buf.sv
// Lap snapshot storage: DEPTH x 24-bit registers with one synchronous
// write port and one combinational read port.
module stopwatch_lap_buf
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [LAP_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [LAP_W-1:0] rdata
);

    logic [LAP_W-1:0] mem [DEPTH];

    // Capture one lap entry on a write strobe.
    // NOTE: the storage has no reset; the controller's lap count decides
    // which entries are valid, so stale contents are never displayed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read of the entry selected for display.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: Moore FSM commanding the time counter, lap capture
// into a small buffer, and lap recall onto registered display digits.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start_pause,
    input  logic                         i_stop,
    input  logic                         i_lap,
    input  logic                         i_recall,
    input  logic [3:0]                   t_ms0,
    input  logic [3:0]                   t_ms1,
    input  logic [3:0]                   t_s0,
    input  logic [3:0]                   t_s1,
    input  logic [3:0]                   t_m0,
    input  logic [3:0]                   t_m1,
    output logic [1:0]                   cnt_ctrl,
    output logic [3:0]                   d_ms0,
    output logic [3:0]                   d_ms1,
    output logic [3:0]                   d_s0,
    output logic [3:0]                   d_s1,
    output logic [3:0]                   d_m0,
    output logic [3:0]                   d_m1,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_cnt,
    output logic [$clog2(LAP_DEPTH)-1:0] o_lap_idx,
    output logic                         o_lap_full,
    output logic                         o_recall
);

    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    sw_state_e        state, state_nxt;
    logic [CNT_W-1:0] lap_cnt, lap_cnt_nxt;
    logic [IDX_W-1:0] lap_idx, lap_idx_nxt;
    logic             lap_we;
    logic             lap_full;
    logic [LAP_W-1:0] live_digits;
    logic [LAP_W-1:0] lap_rdata;
    logic [LAP_W-1:0] disp_q;

    assign live_digits = {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0};
    assign lap_full    = (lap_cnt == CNT_W'(LAP_DEPTH));

    // State, lap count and recall index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lap_cnt <= '0;
            lap_idx <= '0;
        end else begin
            state   <= state_nxt;
            lap_cnt <= lap_cnt_nxt;
            lap_idx <= lap_idx_nxt;
        end
    end

    // Next-state, lap capture and recall index; pulse priority is
    // stop > start_pause > lap > recall.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred; assignments here
    // are blocking because this is combinational logic, not state.
    always_comb begin
        state_nxt   = state;
        lap_cnt_nxt = lap_cnt;
        lap_idx_nxt = lap_idx;
        lap_we      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_start_pause) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else if (i_start_pause) begin
                    state_nxt = ST_PAUSE;
                end else if (i_lap && !lap_full) begin
                    lap_we      = 1'b1;
                    lap_cnt_nxt = lap_cnt + CNT_W'(1);
                end
            end
            ST_PAUSE: begin
                if (i_stop) begin
                    state_nxt = ST_IDLE;
                end else if (i_start_pause) begin
                    state_nxt = ST_RUN;
                end else if (i_recall && (lap_cnt != '0)) begin
                    state_nxt   = ST_RECALL;
                    lap_idx_nxt = '0;
                end
            end
            ST_RECALL: begin
                if (i_stop) begin
                    state_nxt = ST_PAUSE;
                end else if (i_start_pause) begin
                    state_nxt = ST_RUN;
                end else if (i_recall) begin
                    if ({1'b0, lap_idx} == lap_cnt - CNT_W'(1)) begin
                        lap_idx_nxt = '0;
                    end else begin
                        lap_idx_nxt = lap_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Any transition into (or stay in) IDLE forgets all stored laps.
        if (state_nxt == ST_IDLE) begin
            lap_cnt_nxt = '0;
            lap_idx_nxt = '0;
        end
    end

    stopwatch_lap_buf #(
        .DEPTH (LAP_DEPTH)
    ) u_lap_buf (
        .clk   (clk),
        .we    (lap_we),
        .waddr (lap_cnt[IDX_W-1:0]),
        .wdata (live_digits),
        .raddr (lap_idx),
        .rdata (lap_rdata)
    );

    // Registered display: selected lap while recalling, live time otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else if (state == ST_RECALL) begin
            disp_q <= lap_rdata;
        end else begin
            disp_q <= live_digits;
        end
    end

    assign {d_m1, d_m0, d_s1, d_s0, d_ms1, d_ms0} = disp_q;

    assign cnt_ctrl   = state_to_ctrl(state);
    assign o_lap_cnt  = lap_cnt;
    assign o_lap_idx  = lap_idx;
    assign o_lap_full = lap_full;
    assign o_recall   = (state == ST_RECALL);

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl: directed pulse sequences with
// expected outputs queued as each cycle is driven and compared after the edge.
module tb_stopwatch_lap_ctrl;

    localparam int LAP_DEPTH = 4;

    // Pulse bundle encoding {stop, start_pause, lap, recall}.
    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_RC   = 4'b0001;
    localparam logic [3:0] P_LAP  = 4'b0010;
    localparam logic [3:0] P_SP   = 4'b0100;
    localparam logic [3:0] P_ST   = 4'b1000;

    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_HOLD  = 2'b10;

    localparam logic [23:0] L0 = 24'h001234;
    localparam logic [23:0] L1 = 24'h010101;
    localparam logic [23:0] L2 = 24'h020202;
    localparam logic [23:0] LA = 24'h000105;
    localparam logic [23:0] LB = 24'h002233;
    localparam logic [23:0] LC = 24'h014459;

    typedef struct {
        logic [1:0]  ctrl;
        int          cnt;
        int          idx;   // negative: index not checked
        logic        full;
        logic        rec;
        logic [23:0] disp;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       i_start_pause, i_stop, i_lap, i_recall;
    logic [3:0] t_ms0, t_ms1, t_s0, t_s1, t_m0, t_m1;
    logic [1:0] cnt_ctrl;
    logic [3:0] d_ms0, d_ms1, d_s0, d_s1, d_m0, d_m1;
    logic [$clog2(LAP_DEPTH):0]   o_lap_cnt;
    logic [$clog2(LAP_DEPTH)-1:0] o_lap_idx;
    logic       o_lap_full, o_recall;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];

    stopwatch_lap_ctrl #(.LAP_DEPTH(LAP_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start_pause (i_start_pause),
        .i_stop        (i_stop),
        .i_lap         (i_lap),
        .i_recall      (i_recall),
        .t_ms0         (t_ms0),
        .t_ms1         (t_ms1),
        .t_s0          (t_s0),
        .t_s1          (t_s1),
        .t_m0          (t_m0),
        .t_m1          (t_m1),
        .cnt_ctrl      (cnt_ctrl),
        .d_ms0         (d_ms0),
        .d_ms1         (d_ms1),
        .d_s0          (d_s0),
        .d_s1          (d_s1),
        .d_m0          (d_m0),
        .d_m1          (d_m1),
        .o_lap_cnt     (o_lap_cnt),
        .o_lap_idx     (o_lap_idx),
        .o_lap_full    (o_lap_full),
        .o_recall      (o_recall)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ctrl, input int cnt, input int idx,
                                input logic full, input logic rec, input logic [23:0] disp);
        exp_t e;
        e.ctrl = ctrl;
        e.cnt  = cnt;
        e.idx  = idx;
        e.full = full;
        e.rec  = rec;
        e.disp = disp;
        return e;
    endfunction

    function automatic logic [23:0] disp_now();
        return {d_m1, d_m0, d_s1, d_s0, d_ms1, d_ms0};
    endfunction

    // Drive one cycle of pulses and live time, queue the expectation,
    // then compare right after the active edge.
    task automatic cycle(input string tag, input logic [3:0] p, input logic [23:0] live, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        {i_stop, i_start_pause, i_lap, i_recall} = p;
        {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0}   = live;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        check({tag, ".ctrl"}, 32'(cnt_ctrl),   32'(got_e.ctrl));
        check({tag, ".cnt"},  32'(o_lap_cnt),  32'(got_e.cnt));
        if (got_e.idx >= 0) check({tag, ".idx"}, 32'(o_lap_idx), 32'(got_e.idx));
        check({tag, ".full"}, 32'(o_lap_full), 32'(got_e.full));
        check({tag, ".rec"},  32'(o_recall),   32'(got_e.rec));
        check({tag, ".disp"}, 32'(disp_now()), 32'(got_e.disp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, 32'(cnt_ctrl),   32'd0);
        check({tag, ".cnt"},  32'(o_lap_cnt),  32'd0);
        check({tag, ".idx"},  32'(o_lap_idx),  32'd0);
        check({tag, ".full"}, 32'(o_lap_full), 32'd0);
        check({tag, ".rec"},  32'(o_recall),   32'd0);
        check({tag, ".disp"}, 32'(disp_now()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] laps [3];
        laps[0] = LA;
        laps[1] = LB;
        laps[2] = LC;

        rst_n = 1'b0;
        {i_stop, i_start_pause, i_lap, i_recall} = P_NONE;
        {t_m1, t_m0, t_s1, t_s0, t_ms1, t_ms0}   = L0;
        #25;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start at cycle 5, stop at cycle 20.
        for (int c = 0; c < 5; c++) cycle("s1.idle", P_NONE, L0, mk(C_CLEAR, 0, 0, 0, 0, L0));
        cycle("s1.start", P_SP, L0, mk(C_RUN, 0, 0, 0, 0, L0));
        for (int c = 6; c < 20; c++) cycle("s1.run", P_NONE, L0, mk(C_RUN, 0, 0, 0, 0, L0));
        cycle("s1.stop", P_ST, L0, mk(C_CLEAR, 0, 0, 0, 0, L0));

        // Five laps at 00:12:34: the fifth is dropped once full.
        cycle("s2.start", P_SP, L0, mk(C_RUN, 0, 0, 0, 0, L0));
        for (int k = 1; k <= 5; k++) begin
            cycle($sformatf("s2.lap%0d", k), P_LAP, L0,
                  mk(C_RUN, (k > 4) ? 4 : k, 0, (k >= 4), 0, L0));
        end
        cycle("s2.pause",  P_SP,   L1, mk(C_HOLD, 4, 0, 1, 0, L1));
        cycle("s2.recall", P_RC,   L1, mk(C_HOLD, 4, 0, 1, 1, L1));
        cycle("s2.entry0", P_NONE, L1, mk(C_HOLD, 4, 0, 1, 1, L0));
        cycle("s2.back",   P_ST,   L1, mk(C_HOLD, 4, 0, 1, 0, L0));
        cycle("s2.stop",   P_ST,   L1, mk(C_CLEAR, 0, 0, 0, 0, L1));

        // Three distinct laps, then recall through them with wrap.
        cycle("s3.start", P_SP,         L1, mk(C_RUN, 0, 0, 0, 0, L1));
        cycle("s3.lapA",  P_LAP,        LA, mk(C_RUN, 1, 0, 0, 0, LA));
        cycle("s3.lapB",  P_LAP,        LB, mk(C_RUN, 2, 0, 0, 0, LB));
        cycle("s3.lapC",  P_LAP | P_RC, LC, mk(C_RUN, 3, 0, 0, 0, LC));
        cycle("s3.pause", P_SP | P_RC,  L2, mk(C_HOLD, 3, 0, 0, 0, L2));
        for (int k = 0; k < 4; k++) begin
            cycle($sformatf("s3.rc%0d", k), P_RC, L2,
                  mk(C_HOLD, 3, k % 3, 0, 1, (k == 0) ? L2 : laps[(k - 1) % 3]));
            cycle($sformatf("s3.show%0d", k), P_NONE, L2,
                  mk(C_HOLD, 3, k % 3, 0, 1, laps[k % 3]));
        end
        cycle("s3.resume", P_SP | P_RC, L2, mk(C_RUN, 3, -1, 0, 0, LA));

        // Stop and start_pause together in RUN: stop wins, laps cleared.
        cycle("s4.stop_sp", P_ST | P_SP | P_LAP, L2, mk(C_CLEAR, 0, 0, 0, 0, L2));

        // Recall with no laps is ignored.
        cycle("s5.start",   P_SP,   L2, mk(C_RUN, 0, 0, 0, 0, L2));
        cycle("s5.pause",   P_SP,   L2, mk(C_HOLD, 0, 0, 0, 0, L2));
        cycle("s5.rc_none", P_RC,   L2, mk(C_HOLD, 0, 0, 0, 0, L2));
        cycle("s5.run",     P_SP,   L2, mk(C_RUN, 0, 0, 0, 0, L2));
        cycle("s5.lap",     P_LAP,  LA, mk(C_RUN, 1, 0, 0, 0, LA));
        cycle("s5.pause2",  P_SP,   L2, mk(C_HOLD, 1, 0, 0, 0, L2));
        cycle("s5.recall",  P_RC,   L2, mk(C_HOLD, 1, 0, 0, 1, L2));
        cycle("s5.show",    P_NONE, L2, mk(C_HOLD, 1, 0, 0, 1, LA));

        // Asynchronous reset in the middle of a low clock phase.
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("s5.async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("s5.post_start", P_SP, L2, mk(C_RUN, 0, 0, 0, 0, L2));
        cycle("s5.post_pause", P_SP, L2, mk(C_HOLD, 0, 0, 0, 0, L2));
        cycle("s5.post_rc",    P_RC, L2, mk(C_HOLD, 0, 0, 0, 0, L2));
        cycle("s5.idle",       P_NONE, L2, mk(C_HOLD, 0, 0, 0, 0, L2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
